// File: rtl/xmint_pkg.sv
// Shared constants and types for the xmint demultiplexer family.
// The drop counter width is fixed here so every block reports drops identically.
package xmint_pkg;

  localparam int XMINT_DROP_CNT_W = 16;

  typedef logic [XMINT_DROP_CNT_W-1:0] dropCount_t;

endpackage : xmint_pkg

// File: rtl/xmint_demux_slot.sv
// One-entry registered output slot for a single demux channel.
// The parent only asserts i_load when the slot is empty or draining this cycle.
module xmint_demux_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Data only changes on a load, so it holds its last value after a plain drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : xmint_demux_slot

// File: rtl/xmint_demux.sv
// Routes each accepted input beat to one of N single-entry output slots.
// Beats addressed past the last channel are accepted and dropped, with a saturating count.
module xmint_demux
  import xmint_pkg::*;
#(
  parameter int  N                = 3,
  parameter int  DEMUX_DATA_WIDTH = 32,
  localparam int SEL_W            = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DEMUX_DATA_WIDTH-1:0]            in_data,
  input  logic [SEL_W-1:0]                       in_sel,
  output logic [N-1:0]                           out_valid,
  input  logic [N-1:0]                           out_ready,
  output logic [N-1:0][DEMUX_DATA_WIDTH-1:0]     out_data,
  output logic                                   drop_pulse,
  output logic [XMINT_DROP_CNT_W-1:0]            drop_count
);

  logic [31:0] w_selExt;
  logic        w_inRange;
  logic        w_selReady;
  logic        w_accept;
  logic        w_drop;
  logic [N-1:0] w_load;

  logic       r_dropPulse;
  dropCount_t r_dropCount;

  assign w_selExt  = 32'(in_sel);
  assign w_inRange = (w_selExt < 32'(N));

  // Out-of-range selects keep the default of 1 so stray beats are always swallowed.
  always_comb begin
    w_selReady = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (w_selExt == 32'(i)) begin
        w_selReady = !out_valid[i] || out_ready[i];
      end
    end
  end

  assign in_ready = !rst && w_selReady;
  assign w_accept = in_valid && in_ready;
  assign w_drop   = w_accept && !w_inRange;

  for (genvar g = 0; g < N; g++) begin : gen_slot
    assign w_load[g] = w_accept && (w_selExt == 32'(g));

    xmint_demux_slot #(
      .W (DEMUX_DATA_WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[g]),
      .i_data  (in_data),
      .i_ready (out_ready[g]),
      .o_valid (out_valid[g]),
      .o_data  (out_data[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropPulse <= 1'b0;
      r_dropCount <= '0;
    end else begin
      r_dropPulse <= w_drop;
      if (w_drop && (r_dropCount != '1)) begin
        r_dropCount <= r_dropCount + 1'b1;
      end
    end
  end

  assign drop_pulse = r_dropPulse;
  assign drop_count = r_dropCount;

endmodule : xmint_demux

// File: tb/tb_xmint_demux.sv
// Directed self-checking bench for xmint_demux with N=3 and 32-bit beats.
// Inputs change 1ns after each rising edge; outputs are checked before the next edge.
module tb_xmint_demux;

  localparam int N = 3;
  localparam int W = 32;

  logic              clk;
  logic              rst;
  logic              inValid;
  logic              inReady;
  logic [W-1:0]      inData;
  logic [1:0]        inSel;
  logic [N-1:0]      outValid;
  logic [N-1:0]      outReady;
  logic [N-1:0][W-1:0] outData;
  logic              dropPulse;
  logic [15:0]       dropCount;

  int checks   = 0;
  int failures = 0;

  xmint_demux #(
    .N                (N),
    .DEMUX_DATA_WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_data    (inData),
    .in_sel     (inSel),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .drop_pulse (dropPulse),
    .drop_count (dropCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    inData   = '0;
    inSel    = '0;
    outReady = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_in_ready", 64'(inReady), 64'd0);
    checkOutput("rst_out_valid", 64'(outValid), 64'd0);
    checkOutput("rst_out_data0", 64'(outData[0]), 64'd0);
    checkOutput("rst_out_data2", 64'(outData[2]), 64'd0);
    checkOutput("rst_drop_pulse", 64'(dropPulse), 64'd0);
    checkOutput("rst_drop_count", 64'(dropCount), 64'd0);
    rst = 1'b0;
    tick();

    // Single beat to channel 1 with all sinks ready
    outReady = 3'b111;
    inValid  = 1'b1;
    inSel    = 2'd1;
    inData   = 32'hA5A5_0001;
    #1;
    checkOutput("single_in_ready", 64'(inReady), 64'd1);
    tick();
    inValid = 1'b0;
    inData  = 32'hFFFF_FFFF;
    inSel   = 2'd0;
    checkOutput("single_out_valid", 64'(outValid), 64'b010);
    checkOutput("single_out_data1", 64'(outData[1]), 64'hA5A5_0001);
    checkOutput("single_out_data0", 64'(outData[0]), 64'd0);
    checkOutput("single_out_data2", 64'(outData[2]), 64'd0);
    tick();
    checkOutput("single_drained_valid", 64'(outValid), 64'd0);
    checkOutput("single_hold_data1", 64'(outData[1]), 64'hA5A5_0001);

    // Backpressure on channel 0
    outReady = 3'b110;
    inValid  = 1'b1;
    inSel    = 2'd0;
    inData   = 32'h1111_1111;
    #1;
    checkOutput("bp_first_ready", 64'(inReady), 64'd1);
    tick();
    inData = 32'h2222_2222;
    #1;
    checkOutput("bp_second_blocked", 64'(inReady), 64'd0);
    checkOutput("bp_valid0", 64'(outValid), 64'b001);
    checkOutput("bp_data0", 64'(outData[0]), 64'h1111_1111);
    tick();
    checkOutput("bp_data0_stable", 64'(outData[0]), 64'h1111_1111);
    checkOutput("bp_valid0_stable", 64'(outValid), 64'b001);
    outReady = 3'b111;
    #1;
    checkOutput("bp_drain_refill_ready", 64'(inReady), 64'd1);
    tick();
    inValid = 1'b0;
    checkOutput("bp_second_valid", 64'(outValid), 64'b001);
    checkOutput("bp_second_data", 64'(outData[0]), 64'h2222_2222);
    tick();
    checkOutput("bp_empty", 64'(outValid), 64'd0);

    // Eight back-to-back beats to channel 2
    inValid = 1'b1;
    inSel   = 2'd2;
    for (int k = 0; k < 8; k++) begin
      inData = 32'hC0DE_0000 + 32'(k);
      #1;
      checkOutput($sformatf("stream_ready_%0d", k), 64'(inReady), 64'd1);
      tick();
      checkOutput($sformatf("stream_valid_%0d", k), 64'(outValid), 64'b100);
      checkOutput($sformatf("stream_data_%0d", k), 64'(outData[2]), 64'hC0DE_0000 + 64'(k));
    end
    inValid = 1'b0;
    tick();
    checkOutput("stream_end_valid", 64'(outValid), 64'd0);

    // Out-of-range select is dropped
    inValid = 1'b1;
    inSel   = 2'd3;
    inData  = 32'hDEAD_BEEF;
    #1;
    checkOutput("drop_in_ready", 64'(inReady), 64'd1);
    tick();
    inValid = 1'b0;
    checkOutput("drop_no_valid", 64'(outValid), 64'd0);
    checkOutput("drop_pulse_high", 64'(dropPulse), 64'd1);
    checkOutput("drop_count_one", 64'(dropCount), 64'd1);
    tick();
    checkOutput("drop_pulse_low", 64'(dropPulse), 64'd0);
    checkOutput("drop_count_hold", 64'(dropCount), 64'd1);

    // Preload the counter to 0xFFFE, then saturate
    inValid = 1'b1;
    inSel   = 2'd3;
    repeat (16'hFFFD) @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("sat_preload", 64'(dropCount), 64'hFFFE);
    inValid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    inValid = 1'b0;
    checkOutput("sat_count", 64'(dropCount), 64'hFFFF);
    checkOutput("sat_pulse", 64'(dropPulse), 64'd1);
    tick();
    checkOutput("sat_count_hold", 64'(dropCount), 64'hFFFF);
    checkOutput("sat_pulse_low", 64'(dropPulse), 64'd0);

    // Reset with channels 0 and 1 full
    outReady = 3'b000;
    inValid  = 1'b1;
    inSel    = 2'd0;
    inData   = 32'h0A0A_0A0A;
    tick();
    inSel  = 2'd1;
    inData = 32'h0B0B_0B0B;
    tick();
    inValid = 1'b0;
    checkOutput("prerst_valid", 64'(outValid), 64'b011);
    rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 64'(inReady), 64'd0);
    tick();
    checkOutput("midrst_valid", 64'(outValid), 64'd0);
    checkOutput("midrst_drop_count", 64'(dropCount), 64'd0);
    checkOutput("midrst_data1", 64'(outData[1]), 64'd0);
    rst      = 1'b0;
    outReady = 3'b111;
    tick();
    checkOutput("postrst_valid_a", 64'(outValid), 64'd0);
    tick();
    checkOutput("postrst_valid_b", 64'(outValid), 64'd0);

    // Ignored inputs while in_valid is low, then normal traffic resumes
    inSel  = 2'd2;
    inData = 32'h5555_5555;
    tick();
    checkOutput("idle_ignored", 64'(outValid), 64'd0);
    inValid = 1'b1;
    inSel   = 2'd0;
    inData  = 32'h1234_5678;
    tick();
    inValid = 1'b0;
    checkOutput("resume_valid", 64'(outValid), 64'b001);
    checkOutput("resume_data", 64'(outData[0]), 64'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_xmint_demux
